hw_led_out: RTL
===============

Name: hw_led_out

Overview:
- Avalon-MM slave output PIO that drives board LEDs. It is the write/drive counterpart of the button input PIO slaves.
- Holds an output data register with atomic set/clear aliases.
- Adds a per-bit hardware blink engine (programmable half-period counter), so software can blink status LEDs without polling.
- Sits on the Nios II data master bus alongside the input PIOs; `out_port` goes to FPGA pins.

Parameters:
- WIDTH, 8, number of output bits (1..32).
- PERIOD_W, 26, width of blink half-period register and counter.
- RESET_DATA, 0, reset value of DATA register.
- RESET_PERIOD, 25000000, reset value of PERIOD (0.5 s at 50 MHz).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  3  word address of register
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe, qualified by chipselect
- writedata  input  32  write data
- readdata  output  32  registered read data
- out_port  output  WIDTH  registered LED drive

Behaviour:
- Interface: one clock, `clk`; reset is asynchronous and active-low, `reset_n`. All flops clear/preset on reset_n low, independent of clk.
- Write strobe: `wr = chipselect & ~write_n`, sampled at the rising edge; zero wait states.
- Register map (word address):
  - 0 DATA: RW, WIDTH bits.
  - 1 BLINK_EN: RW, WIDTH bits; per-bit blink mask.
  - 2 PERIOD: RW, PERIOD_W bits.
  - 3 STATUS: RO; bit0 = phase, bits[PERIOD_W:1] = counter.
  - 4 OUTSET: WO; DATA <= DATA | writedata[WIDTH-1:0].
  - 5 OUTCLEAR: WO; DATA <= DATA & ~writedata[WIDTH-1:0].
  - 6, 7: reserved.
- Read path: readdata <= mux(address) every clock edge, not gated by any read strobe. Read latency is 1 cycle.
  - Unused upper bits read 0.
  - Addresses 4–7 read 0.
- Writes to STATUS and reserved addresses are ignored. Writedata bits above WIDTH/PERIOD_W are ignored.
- Reset values:
  - DATA = RESET_DATA, BLINK_EN = 0, PERIOD = RESET_PERIOD.
  - counter = 0, phase = 1.
  - readdata = 0, out_port = RESET_DATA[WIDTH-1:0].
- Blink engine (two states via phase: ON = 1, OFF = 0):
  - PERIOD != 0: counter increments each cycle. When counter == PERIOD-1, counter <= 0 and phase toggles. Each phase therefore lasts exactly PERIOD cycles.
  - PERIOD == 0: counter held 0, phase held 1 (blinking bits steady at DATA value).
  - Write to PERIOD: counter <= 0, phase <= 1 on the same edge; this overrides a coincident wrap.
  - Counter never exceeds PERIOD-1. If PERIOD is rewritten smaller, the restart guarantees this.
- Output: out_port[i] <= DATA[i] & (~BLINK_EN[i] | phase), registered.
  - A DATA/BLINK_EN write at edge E appears on out_port at edge E+1.
  - A phase toggle at edge E appears on out_port at edge E+1.
  - Output is glitch-free.
- Simultaneous events:
  - A write and a phase wrap in the same cycle are both applied.
  - OUTSET/OUTCLEAR read-modify-write uses current DATA; no lost updates because only one write can occur per cycle.
- Reset mid-blink: immediate return to reset values; blinking resumes from phase 1, counter 0 after release.

Decomposition:
- Shared package `hw_pio_pkg`:
  - Address constants ADDR_DATA=0, ADDR_BLINK_EN=1, ADDR_PERIOD=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5.
  - STATUS bit-position constants.
- One sub-module `hw_blink_timer` (PERIOD_W):
  - Inputs: clk, reset_n, period, restart.
  - Outputs: phase, count.
  - Holds the counter/phase logic.
- Top holds registers, read mux, output register.

Test Plan:
- Reset with RESET_DATA=8'hA5 -> out_port=8'hA5, readdata=0; read addr 2 -> 25000000 one cycle after address applied.
- Write DATA=8'h3C at edge E -> out_port=8'h3C at E+1; read addr 0 returns 32'h0000003C; read addr 6 returns 0.
- DATA=8'h0F; OUTSET 8'hF0 -> 8'hFF; OUTCLEAR 8'h81 -> 8'h7E; writes to addr 3 leave STATUS unchanged.
- PERIOD=4, BLINK_EN=8'h01, DATA=8'h03 -> out_port alternates 8'h03/8'h02 every exactly 4 cycles; STATUS counter cycles 0..3.
- PERIOD rewritten to 2 while counter=3 -> counter=0, phase=1 next edge, then toggles every 2 cycles; PERIOD=0 -> out_port steady 8'h03.
- Assert reset_n mid-OFF-phase between clock edges -> outputs reach reset values without a clock edge; after release, phase=1, first toggle after PERIOD cycles.

Source files
------------

// File: rtl/hw_pio_pkg.sv
// Shared register-map constants for the PIO slave family (LED output + button inputs).
// STATUS packs the blink phase in bit 0 with the half-period counter directly above it.
package hw_pio_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_CNT_LSB   = 1;

    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } blink_phase_e;

endpackage

// File: rtl/hw_blink_timer.sv
// Half-period blink timer: counts 0..period-1, toggling phase on each wrap.
// A restart (PERIOD write) or a zero period forces counter 0 / phase ON.
module hw_blink_timer
    import hw_pio_pkg::*;
#(
    parameter int PERIOD_W = 26
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase,
    output logic [PERIOD_W-1:0] count
);

    localparam logic [PERIOD_W-1:0] CNT_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    blink_phase_e        r_phase;
    blink_phase_e        w_phase_nxt;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] w_cnt_nxt;
    logic                w_wrap;

    assign w_wrap = (r_cnt == (period - CNT_ONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= PH_ON;
            r_cnt   <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Restart has priority over a coincident wrap so a shrunken period never
    // leaves the counter beyond its new terminal value.
    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        if (restart || (period == '0)) begin
            w_phase_nxt = PH_ON;
            w_cnt_nxt   = '0;
        end else if (w_wrap) begin
            w_phase_nxt = (r_phase == PH_ON) ? PH_OFF : PH_ON;
            w_cnt_nxt   = '0;
        end else begin
            w_cnt_nxt   = r_cnt + CNT_ONE;
        end
    end

    assign phase = r_phase;
    assign count = r_cnt;

endmodule

// File: rtl/hw_led_out.sv
// Avalon-MM LED output PIO: DATA with set/clear aliases, per-bit blink mask,
// registered read data (1-cycle latency) and registered, glitch-free LED drive.
module hw_led_out
    import hw_pio_pkg::*;
#(
    parameter int          WIDTH        = 8,
    parameter int          PERIOD_W     = 26,
    parameter logic [31:0] RESET_DATA   = 32'h0,
    parameter int unsigned RESET_PERIOD = 25000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [WIDTH-1:0]  out_port
);

    localparam logic [WIDTH-1:0]    RST_DATA   = RESET_DATA[WIDTH-1:0];
    localparam logic [PERIOD_W-1:0] RST_PERIOD = RESET_PERIOD[PERIOD_W-1:0];

    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_blink_en;
    logic [PERIOD_W-1:0] r_period;
    logic [31:0]         r_readdata;
    logic [WIDTH-1:0]    r_out;

    logic                w_wr;
    logic                w_restart;
    logic                w_phase;
    logic [PERIOD_W-1:0] w_count;
    logic [31:0]         w_rdata;
    logic [WIDTH-1:0]    w_wdata;
    logic                w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_restart = w_wr && (address == ADDR_PERIOD);
    assign w_wdata   = writedata[WIDTH-1:0];
    assign w_unused  = ^writedata;

    hw_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_blink (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (r_period),
        .restart (w_restart),
        .phase   (w_phase),
        .count   (w_count)
    );

    // OUTSET/OUTCLEAR are read-modify-write on the current DATA; one bus
    // write per cycle means no update can be lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= RST_DATA;
            r_blink_en <= '0;
            r_period   <= RST_PERIOD;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:     r_data     <= w_wdata;
                ADDR_BLINK_EN: r_blink_en <= w_wdata;
                ADDR_PERIOD:   r_period   <= writedata[PERIOD_W-1:0];
                ADDR_OUTSET:   r_data     <= r_data | w_wdata;
                ADDR_OUTCLEAR: r_data     <= r_data & ~w_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:     w_rdata[WIDTH-1:0]    = r_data;
            ADDR_BLINK_EN: w_rdata[WIDTH-1:0]    = r_blink_en;
            ADDR_PERIOD:   w_rdata[PERIOD_W-1:0] = r_period;
            ADDR_STATUS: begin
                w_rdata[STATUS_PHASE_BIT]             = w_phase;
                w_rdata[STATUS_CNT_LSB +: PERIOD_W]   = w_count;
            end
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
            r_out      <= RST_DATA;
        end else begin
            r_readdata <= w_rdata;
            r_out      <= r_data & (~r_blink_en | {WIDTH{w_phase}});
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out;

endmodule
